bless_port_alloc: RTL and testbench
===================================

# bless_port_alloc

Single-cycle output-port allocator for the bufferless (BLESS) deflection router. Each cycle it takes the preferred-port vectors from the per-input route-computation units, grants every valid network flit exactly one output (productive if possible, otherwise deflected), admits a local injection flit into a leftover network port, and registers the resulting crossbar selects. It sits between route computation and the crossbar/output latches, and holds the round-robin priority state and deflection statistics.

## Interface
- `NUM_IN`, 4, network input ports (N=0, E=1, S=2, W=3)
- `NUM_PORT`, 5, output ports (N, E, S, W, local eject=4); same encoding as the RC preferred-port vector
- `STARVE_LIMIT`, 8, consecutive blocked-injection cycles before `inj_starve` asserts
- `clk`  in  1  router clock; all state on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `in_valid`  in  4  flit present on network input i
- `in_prefer`  in  20  preferred-port vector of input i at `[5*i +: 5]`
- `inj_valid`  in  1  local flit waiting to inject
- `inj_prefer`  in  5  preferred-port vector of injection flit; bit 4 ignored
- `inj_ready`  out  1  combinational; injection accepted this cycle when `inj_valid && inj_ready`
- `out_valid`  out  5  registered; output port p carries a flit
- `out_sel`  out  15  registered; source for port p at `[3*p +: 3]`: 0–3 network input, 4 injection
- `deflect_cnt`  out  16  registered; saturating count of deflected network flits
- `inj_starve`  out  1  registered; injection blocked `STARVE_LIMIT` or more consecutive cycles

## Operation
- Priority order: inputs `rr_ptr`, `rr_ptr+1`, … mod 4. Injection is always last.
- Pass over inputs in priority order; skip invalid. Input i takes the lowest-index free port p with `in_prefer[i][p]` set (p in 0..4). If none is free, i is deflected to the lowest-index free port in 0..3. Port 4 is never a deflection target.
- Feasibility: at most 4 network flits and 4 network ports, so every valid network flit is always granted. An unmatched valid flit is a design error; the bench asserts on it.
- At most one ejection per cycle. A second flit preferring only port 4 is deflected.
- Injection: `inj_ready` = at least one of ports 0..3 is free after the network pass. The injected flit takes the lowest-index free preferred port in 0..3, else the lowest-index free port in 0..3.
- Ports not granted: `out_valid[p]=0`, `out_sel` field = 0.
- `rr_ptr` (2 bits): increments by 1 mod 4 in any cycle where some `in_valid` is set; otherwise holds.
- `deflect_cnt`: adds the number of network flits granted a non-preferred port this cycle (0..4); saturates at 16'hFFFF. Injection flits are not counted.
- Starvation counter: increments on `inj_valid && !inj_ready`, saturating at `STARVE_LIMIT`. Clears on accept or when `inj_valid=0`. `inj_starve` = counter ≥ `STARVE_LIMIT`.
- A vector with all bits zero on a valid input is treated as "no preference" and deflected.

## Timing
- Allocation is combinational from `in_*`/`inj_*`. `out_valid`/`out_sel` appear one cycle after the inputs are sampled (latency 1, no stall, full throughput).
- `inj_ready` is valid in the same cycle as the inputs and depends only on `in_valid`/`in_prefer`, never on `inj_valid`.
- Reset (asynchronous assert, synchronous release): `out_valid=0`, `out_sel=0`, `deflect_cnt=0`, `inj_starve=0`, `rr_ptr=0`, starvation counter 0. `inj_ready` follows the combinational rule and is 1 when no inputs are valid.
- Reset asserted mid-operation clears registered grants immediately. Flits in flight are lost; upstream handles this.

## Structure
- Shared package/header (`global.vh`): port indices N/E/S/W/LOCAL, `NUM_PORT`, source encoding (INJ=4).
- Sub-module `bless_grant_stage`: one priority step. Inputs are a free-port mask, a preferred vector, valid, and whether deflection is allowed. Outputs are the chosen one-hot port, the updated free mask, and a deflected flag. Instantiate five times in a chain; the top level rotates inputs by `rr_ptr` and registers results.

## Test plan
- Reset, then idle -> all outputs 0; `inj_ready=1`; `rr_ptr` stays 0.
- `rr_ptr=0`; N and E both prefer 5'b00010 -> next cycle E port sel=0, N port (0) sel=1; `deflect_cnt=1`; `rr_ptr=1`.
- Two inputs with prefer 5'b10000 -> one ejects on port 4, the other goes to port 0; repeat with swapped priority and check the winner swaps.
- All 4 inputs valid, `inj_valid=1` -> `inj_ready=0`; after 8 such cycles `inj_starve=1`; one idle input -> accept, `inj_starve` clears next cycle.
- 3 inputs valid, injection prefers 5'b00100 with S free -> `out_sel[S]=4`.
- Preload `deflect_cnt=16'hFFFE` (via cycles), deflect 2 -> saturates at FFFF; assert `rst_n` mid-traffic -> outputs 0 asynchronously.

Source files
------------

// File: rtl/bless_port_alloc_pkg.sv
// bless_port_alloc_pkg: port/source encodings and one-hot helper shared by the allocator files
package bless_port_alloc_pkg;

    localparam int NUM_PORT = 5;
    localparam int NUM_NET  = 4;

    typedef enum logic [2:0] {
        PORT_N     = 3'd0,
        PORT_E     = 3'd1,
        PORT_S     = 3'd2,
        PORT_W     = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    // Crossbar source code for the local injection flit
    localparam logic [2:0] SRC_INJ = 3'd4;

    // Ports a flit may be deflected to; ejection is never a deflection target
    localparam logic [NUM_PORT-1:0] NET_PORTS = 5'b01111;

    // Isolate the lowest set bit, giving a one-hot (or zero) vector
    function automatic logic [NUM_PORT-1:0] lowest_one(input logic [NUM_PORT-1:0] v);
        return v & (~v + 5'd1);
    endfunction

endpackage

// File: rtl/bless_grant_stage.sv
// bless_grant_stage: one priority step, granting a flit its preferred free port or a free network port
module bless_grant_stage
    import bless_port_alloc_pkg::*;
(
    input  logic [NUM_PORT-1:0] free_i,
    input  logic [NUM_PORT-1:0] prefer_i,
    input  logic                valid_i,
    input  logic                defl_en_i,
    output logic [NUM_PORT-1:0] grant_o,
    output logic [NUM_PORT-1:0] free_o,
    output logic                defl_o
);

    logic [NUM_PORT-1:0] hit;
    logic [NUM_PORT-1:0] spare;

    // Productive port first, else lowest free network port; claimed port leaves the free mask
    always_comb begin
        hit     = lowest_one(free_i & prefer_i);
        spare   = lowest_one(free_i & NET_PORTS);
        grant_o = !valid_i ? '0 : (|hit) ? hit : defl_en_i ? spare : '0;
        defl_o  = valid_i && !(|hit) && (|grant_o);
        free_o  = free_i & ~grant_o;
    end

endmodule

// File: rtl/bless_port_alloc.sv
// bless_port_alloc: round-robin BLESS output-port allocator with injection, deflection stats and starvation flag
module bless_port_alloc #(
    parameter int NUM_IN       = 4,
    parameter int NUM_PORT     = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_PORT*NUM_IN-1:0] in_prefer,
    input  logic                       inj_valid,
    input  logic [NUM_PORT-1:0]        inj_prefer,
    output logic                       inj_ready,
    output logic [NUM_PORT-1:0]        out_valid,
    output logic [3*NUM_PORT-1:0]      out_sel,
    output logic [15:0]                deflect_cnt,
    output logic                       inj_starve
);

    import bless_port_alloc_pkg::*;

    localparam int IW = $clog2(NUM_IN);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [NUM_PORT-1:0] out_valid_q, out_valid_d;
    logic [3*NUM_PORT-1:0] out_sel_q, out_sel_d;
    logic [15:0]         deflect_cnt_q, deflect_cnt_d;

    logic [IW-1:0]       rot     [NUM_IN];
    logic [2:0]          st_src  [NUM_IN+1];
    logic [NUM_PORT-1:0] st_pref [NUM_IN+1];
    logic [NUM_IN:0]     st_valid;
    logic [NUM_PORT-1:0] grant   [NUM_IN+1];
    logic [NUM_IN:0]     defl;
    logic [16:0]         dsum;

    // Present inputs in round-robin priority order; injection always takes the last stage
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            rot[k]      = rr_ptr_q + IW'(k);
            st_src[k]   = 3'(rot[k]);
            st_valid[k] = in_valid[rot[k]];
            st_pref[k]  = in_prefer[NUM_PORT*rot[k] +: NUM_PORT];
        end
        st_src[NUM_IN]   = SRC_INJ;
        st_valid[NUM_IN] = inj_valid;
        st_pref[NUM_IN]  = inj_prefer & NET_PORTS;
    end

    for (genvar g = 0; g <= NUM_IN; g++) begin : g_stage
        logic [NUM_PORT-1:0] fi;
        logic [NUM_PORT-1:0] fo;
        if (g == 0) begin : g_first
            assign fi = '1;
        end else begin : g_next
            assign fi = g_stage[g-1].fo;
        end
        bless_grant_stage u_stage (
            .free_i   (fi),
            .prefer_i (st_pref[g]),
            .valid_i  (st_valid[g]),
            .defl_en_i(1'b1),
            .grant_o  (grant[g]),
            .free_o   (fo),
            .defl_o   (defl[g])
        );
    end

    // Ready depends only on the network pass, never on inj_valid
    assign inj_ready = |(g_stage[NUM_IN].fi & NET_PORTS);

    // Next-state: crossbar selects, saturating stats, priority rotation and starvation tracking
    always_comb begin
        out_valid_d = ~g_stage[NUM_IN].fo;
        out_sel_d   = '0;
        for (int k = 0; k <= NUM_IN; k++)
            for (int p = 0; p < NUM_PORT; p++)
                if (grant[k][p]) out_sel_d[3*p +: 3] = st_src[k];
        dsum          = {1'b0, deflect_cnt_q} + 17'($countones(defl & {1'b0, {NUM_IN{1'b1}}}));
        deflect_cnt_d = dsum[16] ? 16'hFFFF : dsum[15:0];
        rr_ptr_d      = rr_ptr_q + IW'(|in_valid);
        starve_d      = !(inj_valid && !inj_ready) ? '0 :
                        (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end

    // State registers, cleared asynchronously so grants drop as soon as reset asserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            starve_q      <= '0;
            out_valid_q   <= '0;
            out_sel_q     <= '0;
            deflect_cnt_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            starve_q      <= starve_d;
            out_valid_q   <= out_valid_d;
            out_sel_q     <= out_sel_d;
            deflect_cnt_q <= deflect_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sel     = out_sel_q;
    assign deflect_cnt = deflect_cnt_q;
    assign inj_starve  = starve_q >= SW'(STARVE_LIMIT);

endmodule

// File: tb/tb_bless_port_alloc.sv
// tb_bless_port_alloc: directed vectors, corner sequences and randomized model check for bless_port_alloc
module tb_bless_port_alloc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [19:0] in_prefer = '0;
    logic        inj_valid = 1'b0;
    logic [4:0]  inj_prefer = '0;
    logic        inj_ready;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;
    logic [15:0] deflect_cnt;
    logic        inj_starve;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bless_port_alloc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_prefer  (in_prefer),
        .inj_valid  (inj_valid),
        .inj_prefer (inj_prefer),
        .inj_ready  (inj_ready),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .deflect_cnt(deflect_cnt),
        .inj_starve (inj_starve)
    );

    typedef struct {
        logic [3:0]  v;
        logic [19:0] pr;
        logic        iv;
        logic [4:0]  ip;
        logic [4:0]  ov;
        logic [14:0] os;
        logic        rdy;
        logic [15:0] dc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = '0;
        in_prefer  = '0;
        inj_valid  = 1'b0;
        inj_prefer = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [19:0] pr, input logic iv, input logic [4:0] ip);
        in_valid   = v;
        in_prefer  = pr;
        inj_valid  = iv;
        inj_prefer = ip;
    endtask

    // Reference allocation: walk inputs in priority order using a set of taken ports
    task automatic model(input logic [3:0] v, input logic [19:0] pr, input logic iv, input logic [4:0] ip,
                         input int rr, output logic [4:0] ov, output logic [14:0] os,
                         output int nd, output logic rdy);
        bit taken [5];
        int p;
        for (int q = 0; q < 5; q++) taken[q] = 0;
        ov = '0;
        os = '0;
        nd = 0;
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (rr + k) % 4;
            if (v[i]) begin
                p = -1;
                for (int q = 0; q < 5; q++)
                    if (p < 0 && pr[5*i+q] && !taken[q]) p = q;
                if (p < 0) begin
                    nd++;
                    for (int q = 0; q < 4; q++)
                        if (p < 0 && !taken[q]) p = q;
                end
                taken[p] = 1;
                ov[p] = 1'b1;
                os[3*p +: 3] = 3'(i);
            end
        end
        for (int q = 0; q < 4; q++) if (!taken[q]) rdy = 1'b1;
        if (iv && rdy) begin
            p = -1;
            for (int q = 0; q < 4; q++)
                if (p < 0 && ip[q] && !taken[q]) p = q;
            for (int q = 0; q < 4; q++)
                if (p < 0 && !taken[q]) p = q;
            ov[p] = 1'b1;
            os[3*p +: 3] = 3'd4;
        end
    endtask

    function automatic logic [4:0] rand_pref();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 5'(1 << $urandom_range(0, 4));
        if (r < 8) return 5'($urandom);
        return 5'd0;
    endfunction

    vec_t vecs [7];

    initial begin
        logic [4:0]  e_ov, n_ov;
        logic [14:0] e_os, n_os;
        logic        n_rdy;
        logic [3:0]  prev_v;
        int          e_dc, e_st, rr, nd, found, expect_cnt;
        logic [19:0] pr;

        vecs[0] = '{4'b0000, 20'h00000, 1'b0, 5'b00000, 5'b00000, 15'h0000, 1'b1, 16'd0};
        vecs[1] = '{4'b0011, 20'h00042, 1'b0, 5'b00000, 5'b00011, 15'h0001, 1'b1, 16'd1};
        vecs[2] = '{4'b0011, 20'h00210, 1'b0, 5'b00000, 5'b10001, 15'h0001, 1'b1, 16'd1};
        vecs[3] = '{4'b1111, 20'h08421, 1'b1, 5'b00000, 5'b01111, 15'h0688, 1'b0, 16'd3};
        vecs[4] = '{4'b1011, 20'h40041, 1'b1, 5'b00100, 5'b01111, 15'h0708, 1'b1, 16'd0};
        vecs[5] = '{4'b0001, 20'h00000, 1'b0, 5'b00000, 5'b00001, 15'h0000, 1'b1, 16'd1};
        vecs[6] = '{4'b0000, 20'h00000, 1'b1, 5'b10100, 5'b00100, 15'h0100, 1'b1, 16'd0};

        do_reset();
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_sel", 32'(out_sel), 32'h0);
        check("reset_deflect_cnt", 32'(deflect_cnt), 32'h0);
        check("reset_inj_starve", 32'(inj_starve), 32'h0);
        check("reset_inj_ready", 32'(inj_ready), 32'h1);

        // Directed single-cycle vectors, each from a fresh reset with rr_ptr=0
        for (int n = 0; n < 7; n++) begin
            do_reset();
            drive(vecs[n].v, vecs[n].pr, vecs[n].iv, vecs[n].ip);
            #1;
            check($sformatf("vec%0d_inj_ready", n), 32'(inj_ready), 32'(vecs[n].rdy));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].ov));
            check($sformatf("vec%0d_out_sel", n), 32'(out_sel), 32'(vecs[n].os));
            check($sformatf("vec%0d_deflect_cnt", n), 32'(deflect_cnt), 32'(vecs[n].dc));
        end

        // Idle cycles keep rr_ptr at 0, so input N wins the ejection
        do_reset();
        repeat (3) @(negedge clk);
        drive(4'b0011, 20'h00210, 1'b0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        check("eject_rr0_out_sel", 32'(out_sel), 32'h0001);

        // After one busy cycle rr_ptr=1, so input E wins the ejection instead
        do_reset();
        drive(4'b0001, 20'h00001, 1'b0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        drive(4'b0011, 20'h00210, 1'b0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        check("eject_rr1_out_valid", 32'(out_valid), 32'h11);
        check("eject_rr1_out_sel", 32'(out_sel), 32'h1000);

        // Starvation: eight blocked cycles raise inj_starve, an accept clears it
        do_reset();
        drive(4'b1111, 20'h08421, 1'b1, 5'd0);
        #1;
        check("starve_inj_ready", 32'(inj_ready), 32'h0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 7) check("starve_after7", 32'(inj_starve), 32'h0);
            if (c == 8) check("starve_after8", 32'(inj_starve), 32'h1);
        end
        drive(4'b0111, 20'h00421, 1'b1, 5'd0);
        #1;
        check("starve_accept_ready", 32'(inj_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("starve_cleared", 32'(inj_starve), 32'h0);
        check("starve_inj_on_w", 32'(out_sel[11:9]), 32'h4);

        // Deflection counter saturation: 21844*3 + 2 = 65534, then +2 saturates
        do_reset();
        drive(4'b1111, 20'h08421, 1'b0, 5'd0);
        repeat (21844) @(posedge clk);
        @(negedge clk);
        drive(4'b0111, 20'h00421, 1'b0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        check("sat_fffe", 32'(deflect_cnt), 32'hFFFE);
        @(posedge clk);
        @(negedge clk);
        check("sat_ffff", 32'(deflect_cnt), 32'hFFFF);
        drive(4'b1111, 20'h08421, 1'b0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        check("sat_hold", 32'(deflect_cnt), 32'hFFFF);

        // Asynchronous reset in the middle of a cycle clears grants without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_sel", 32'(out_sel), 32'h0);
        check("async_deflect_cnt", 32'(deflect_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        e_ov = '0; e_os = '0; e_dc = 0; e_st = 0; rr = 0; prev_v = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            check("rnd_out_sel", 32'(out_sel), 32'(e_os));
            check("rnd_deflect_cnt", 32'(deflect_cnt), 32'(e_dc));
            check("rnd_inj_starve", 32'(inj_starve), 32'(e_st >= 8));
            found = 0;
            expect_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                if (prev_v[i]) begin
                    expect_cnt++;
                    for (int p = 0; p < 5; p++)
                        if (out_valid[p] && out_sel[3*p +: 3] == 3'(i)) found++;
                end
            end
            check("rnd_all_granted", 32'(found), 32'(expect_cnt));
            pr = {rand_pref(), rand_pref(), rand_pref(), rand_pref()};
            drive(4'($urandom), pr, 1'($urandom), 5'($urandom));
            #1;
            model(in_valid, in_prefer, inj_valid, inj_prefer, rr, n_ov, n_os, nd, n_rdy);
            check("rnd_inj_ready", 32'(inj_ready), 32'(n_rdy));
            e_ov = n_ov;
            e_os = n_os;
            e_dc = (e_dc + nd > 65535) ? 65535 : e_dc + nd;
            e_st = (inj_valid && !n_rdy) ? ((e_st >= 8) ? 8 : e_st + 1) : 0;
            if (in_valid != 0) rr = (rr + 1) % 4;
            prev_v = in_valid;
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
